fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 21 ++
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/inst_queue.sv | 73 +++++++
 rtl/fetch_ctrl.sv | 130 +++++++++++++
 tb/tb_fetch_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared fetch/decoder constants, FSM encoding and queue entry type
package fetch_ctrl_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;
    typedef logic [INST_W-1:0]      inst_bus_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAITQ = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        inst_addr_bus_t pc;
        inst_bus_t      word;
    } qentry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - memory port, decoder handshake and redirect signals of the fetch unit
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic           jumpEn;
    inst_addr_bus_t jumpAddr;
    logic           memReq;
    inst_addr_bus_t memAddr;
    logic           memGnt;
    logic           memDv;
    logic [7:0]     memDout;
    logic           instValid;
    inst_bus_t      inst;
    inst_addr_bus_t instPc;
    logic           decStall;

    modport master (
        input  jumpEn, jumpAddr, memGnt, memDv, memDout, decStall,
        output memReq, memAddr, instValid, inst, instPc
    );

    modport slave (
        output jumpEn, jumpAddr, memGnt, memDv, memDout, decStall,
        input  memReq, memAddr, instValid, inst, instPc
    );

endinterface

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - power-of-two FIFO of {pc, word} entries with flush and registered head
module inst_queue
    import fetch_ctrl_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  qentry_t       push_data,
    input  logic          pop,
    output qentry_t       head,
    output logic [CW-1:0] count,
    output logic          empty
);

    qentry_t       mem_q [DEPTH];
    qentry_t       mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - byte-serial instruction fetch: request FSM, little-endian word assembly, queue
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int             QDEPTH   = 4,
    parameter inst_addr_bus_t RESET_PC = 32'h0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);

    localparam int          CW = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

    fetch_state_e   state_q, state_d;
    inst_addr_bus_t fetch_pc_q, fetch_pc_d;
    inst_addr_bus_t req_pc_q, req_pc_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [1:0]     req_k_q, req_k_d;
    logic           dv_exp_q, dv_exp_d;
    inst_bus_t      asm_q, asm_d;

    logic          mem_req, accept, byte_in, last_pend, room;
    inst_bus_t     asm_merge;
    logic          q_push, q_pop, q_flush, q_empty;
    qentry_t       q_din, q_head;
    logic [CW-1:0] q_count;

    inst_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (q_flush),
        .push      (q_push),
        .push_data (q_din),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count),
        .empty     (q_empty)
    );

    // dv_exp_q marks the cycle a byte is owed to us; stale bytes after reset or a redirect fall outside it.
    assign accept    = mem_req && bus.memGnt;
    assign byte_in   = bus.memDv && dv_exp_q;
    assign last_pend = dv_exp_q && (req_k_q == 2'd3);
    // The word whose last byte is returning still owns a slot until it is pushed.
    assign room      = ({1'b0, q_count} + {{CW{1'b0}}, last_pend}) < QD;
    assign mem_req   = !rst && (state_q == ST_FETCH) && ((byte_cnt_q != 2'd0) || room);

    always_comb begin
        asm_merge = asm_q;
        asm_merge[{req_k_q, 3'b000} +: 8] = bus.memDout;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        byte_cnt_d = byte_cnt_q;
        req_pc_d   = req_pc_q;
        req_k_d    = req_k_q;
        dv_exp_d   = accept;
        asm_d      = byte_in ? asm_merge : asm_q;
        q_push     = byte_in && (req_k_q == 2'd3);
        q_pop      = !q_empty && !bus.decStall;
        q_flush    = 1'b0;
        q_din      = '{pc: req_pc_q, word: asm_merge};

        if (accept) begin
            req_pc_d   = fetch_pc_q;
            req_k_d    = byte_cnt_q;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end

        case (state_q)
            ST_FETCH: begin
                if (byte_cnt_q == 2'd0 && !room && !q_pop) begin
                    state_d = ST_WAITQ;
                end
            end
            ST_WAITQ: begin
                if (q_pop) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FLUSH: state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase

        if (bus.jumpEn) begin
            fetch_pc_d = bus.jumpAddr;
            byte_cnt_d = 2'd0;
            dv_exp_d   = 1'b0;
            asm_d      = '0;
            q_push     = 1'b0;
            q_pop      = 1'b0;
            q_flush    = 1'b1;
            state_d    = (accept || state_q == ST_FLUSH) ? ST_FLUSH : ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= RESET_PC;
            byte_cnt_q <= 2'd0;
            req_pc_q   <= '0;
            req_k_q    <= 2'd0;
            dv_exp_q   <= 1'b0;
            asm_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            byte_cnt_q <= byte_cnt_d;
            req_pc_q   <= req_pc_d;
            req_k_q    <= req_k_d;
            dv_exp_q   <= dv_exp_d;
            asm_q      <= asm_d;
        end
    end

    assign bus.memReq    = mem_req;
    assign bus.memAddr   = fetch_pc_q + {30'd0, byte_cnt_q};
    assign bus.instValid = !q_empty;
    assign bus.inst      = q_head.word;
    assign bus.instPc    = q_head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl and its instruction queue
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_ctrl_if bus();
    fetch_ctrl #(.QDEPTH(4), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic    uq_flush, uq_push, uq_pop, uq_empty;
    qentry_t uq_din, uq_head;
    logic [2:0] uq_count;
    inst_queue #(.DEPTH(4)) u_q (
        .clk(clk), .rst(rst), .flush(uq_flush), .push(uq_push), .push_data(uq_din),
        .pop(uq_pop), .head(uq_head), .count(uq_count), .empty(uq_empty)
    );

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    qentry_t        exp_inst[$];
    qentry_t        exp_uq[$];
    logic [31:0]    exp_addr[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic qentry_t mk(input logic [31:0] pc, input logic [31:0] word);
        qentry_t e;
        e.pc   = pc;
        e.word = word;
        return e;
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        case (pc)
            32'h000: return 32'h00000013;
            32'h004: return 32'h00100093;
            32'h008: return 32'h00200113;
            32'h00C: return 32'h00308193;
            32'h010: return 32'h00410213;
            32'h100: return 32'hDEADBEEF;
            32'h104: return 32'hCAFEF00D;
            default: return 32'h0BADC0DE;
        endcase
    endfunction

    function automatic logic [7:0] rom_byte(input logic [31:0] addr);
        logic [31:0] w;
        w = rom_word({addr[31:2], 2'b00});
        return w[{addr[1:0], 3'b000} +: 8];
    endfunction

    // memory responder: one-cycle read latency after an accepted request
    initial begin
        logic        r_acc;
        logic [31:0] r_addr;
        bus.memDv   = 1'b0;
        bus.memDout = 8'h00;
        forever begin
            @(negedge clk);
            r_acc  = bus.memReq && bus.memGnt && !rst;
            r_addr = bus.memAddr;
            @(posedge clk);
            #1;
            bus.memDv   = r_acc;
            bus.memDout = r_acc ? rom_byte(r_addr) : 8'h00;
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.memReq && bus.memGnt) begin
            acc_cnt++;
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_addr_unexpected: got %h expected none", bus.memAddr);
            end else begin
                chk("mem_addr", bus.memAddr, exp_addr.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        qentry_t e;
        if (!rst && bus.instValid && !bus.decStall && !bus.jumpEn) begin
            if (exp_inst.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL inst_unexpected: got pc %h inst %h expected none", bus.instPc, bus.inst);
            end else begin
                e = exp_inst.pop_front();
                chk("inst_pc", bus.instPc, e.pc);
                chk("inst_word", bus.inst, e.word);
            end
        end
    end

    always @(negedge clk) begin
        qentry_t e;
        if (!rst && uq_pop && !uq_empty && !uq_flush) begin
            if (exp_uq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL uq_unexpected: got pc %h expected none", uq_head.pc);
            end else begin
                e = exp_uq.pop_front();
                chk("uq_pc", uq_head.pc, e.pc);
                chk("uq_word", uq_head.word, e.word);
            end
        end
    end

    task automatic do_reset();
        rst          = 1'b1;
        bus.jumpEn   = 1'b0;
        bus.jumpAddr = 32'h0;
        bus.memGnt   = 1'b0;
        bus.decStall = 1'b1;
        tick();
        tick();
        chk("rst_memreq", 32'(bus.memReq), 32'd0);
        chk("rst_valid", 32'(bus.instValid), 32'd0);
        rst     = 1'b0;
        acc_cnt = 0;
    endtask

    task automatic jump_test(input bit dbl);
        do_reset();
        bus.memGnt = 1'b1;
        for (int a = 0; a < 3; a++) exp_addr.push_back(32'(a));
        for (int a = 0; a < 4; a++) exp_addr.push_back((dbl ? 32'h104 : 32'h100) + 32'(a));
        exp_inst.push_back(dbl ? mk(32'h104, 32'hCAFEF00D) : mk(32'h100, 32'hDEADBEEF));
        tick();
        tick();
        bus.jumpEn   = 1'b1;
        bus.jumpAddr = 32'h100;
        tick();
        bus.jumpEn   = dbl;
        bus.jumpAddr = 32'h104;
        chk("flush_valid", 32'(bus.instValid), 32'd0);
        chk("flush_memreq", 32'(bus.memReq), 32'd0);
        tick();
        bus.jumpEn = 1'b0;
        if (dbl) begin
            chk("flush2_memreq", 32'(bus.memReq), 32'd0);
            tick();
        end
        chk("jump_target", bus.memAddr, dbl ? 32'h104 : 32'h100);
        repeat (4) tick();
        bus.memGnt = 1'b0;
        tick();
        tick();
        bus.decStall = 1'b0;
        tick();
        bus.decStall = 1'b1;
        chk("jump_addr_drained", 32'(exp_addr.size()), 32'd0);
        chk("jump_inst_drained", 32'(exp_inst.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int   lat;
        bit   found;
        logic        g_pat [7];
        logic [31:0] a_pat [7];

        rst = 1'b1;
        uq_flush = 1'b0; uq_push = 1'b0; uq_pop = 1'b0; uq_din = '0;

        // basic fetch, latency, fill to QDEPTH with decoder stalled
        do_reset();
        chk("reset_pc", bus.memAddr, 32'h0);
        for (int a = 0; a < 16; a++) exp_addr.push_back(32'(a));
        exp_inst.push_back(mk(32'h0, 32'h00000013));
        bus.memGnt = 1'b1;
        lat = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            if (bus.instValid) lat = k;
            else tick();
        end
        chk("first_latency", 32'(lat), 32'd5);
        chk("first_inst", bus.inst, 32'h00000013);
        chk("first_pc", bus.instPc, 32'h0);
        repeat (20) tick();
        chk("full_memreq", 32'(bus.memReq), 32'd0);
        chk("full_accepts", 32'(acc_cnt), 32'd16);
        chk("full_addr_drained", 32'(exp_addr.size()), 32'd0);

        // one pop frees a slot and fetching resumes at 0x10
        for (int a = 0; a < 4; a++) exp_addr.push_back(32'h10 + 32'(a));
        bus.decStall = 1'b0;
        tick();
        bus.decStall = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 2 && !found; k++) begin
            if (bus.memReq && bus.memAddr == 32'h10) found = 1'b1;
            else tick();
        end
        chk("refetch_within2", 32'(found), 32'd1);
        repeat (12) tick();
        chk("refull_memreq", 32'(bus.memReq), 32'd0);
        chk("refull_addr_drained", 32'(exp_addr.size()), 32'd0);
        bus.memGnt = 1'b0;
        exp_inst.push_back(mk(32'h04, 32'h00100093));
        exp_inst.push_back(mk(32'h08, 32'h00200113));
        exp_inst.push_back(mk(32'h0C, 32'h00308193));
        exp_inst.push_back(mk(32'h10, 32'h00410213));
        bus.decStall = 1'b0;
        repeat (6) tick();
        bus.decStall = 1'b1;
        chk("drain_valid", 32'(bus.instValid), 32'd0);
        chk("drain_inst_empty", 32'(exp_inst.size()), 32'd0);

        // redirect without an accepted request, then a grant hole on byte 2
        do_reset();
        bus.jumpEn   = 1'b1;
        bus.jumpAddr = 32'h100;
        tick();
        bus.jumpEn = 1'b0;
        for (int a = 0; a < 4; a++) exp_addr.push_back(32'h100 + 32'(a));
        exp_inst.push_back(mk(32'h100, 32'hDEADBEEF));
        g_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        a_pat = '{32'h100, 32'h101, 32'h102, 32'h102, 32'h102, 32'h102, 32'h103};
        for (int k = 0; k < 7; k++) begin
            chk("hold_memreq", 32'(bus.memReq), 32'd1);
            chk("hold_addr", bus.memAddr, a_pat[k]);
            bus.memGnt = g_pat[k];
            tick();
        end
        bus.memGnt = 1'b0;
        tick();
        tick();
        chk("hold_valid", 32'(bus.instValid), 32'd1);
        bus.decStall = 1'b0;
        tick();
        bus.decStall = 1'b1;
        chk("hold_inst_drained", 32'(exp_inst.size()), 32'd0);
        chk("hold_addr_drained", 32'(exp_addr.size()), 32'd0);

        // redirect with byte 1 in flight, then a second redirect during FLUSH
        jump_test(1'b0);
        jump_test(1'b1);

        // queue unit: full with simultaneous push/pop across the pointer wrap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            uq_push = 1'b1;
            uq_din  = mk(32'h1000 + 32'(4 * i), 32'hA0000000 + 32'(i));
            exp_uq.push_back(uq_din);
            tick();
        end
        uq_push = 1'b0;
        chk("uq_full_count", 32'(uq_count), 32'd4);
        for (int i = 4; i < 7; i++) begin
            uq_push = 1'b1;
            uq_pop  = 1'b1;
            uq_din  = mk(32'h1000 + 32'(4 * i), 32'hA0000000 + 32'(i));
            exp_uq.push_back(uq_din);
            tick();
            chk("uq_pushpop_count", 32'(uq_count), 32'd4);
        end
        uq_push = 1'b0;
        repeat (4) tick();
        uq_pop = 1'b0;
        chk("uq_empty_count", 32'(uq_count), 32'd0);
        uq_push = 1'b1;
        uq_pop  = 1'b1;
        uq_din  = mk(32'h2000, 32'h12345678);
        exp_uq.push_back(uq_din);
        tick();
        uq_push = 1'b0;
        uq_pop  = 1'b0;
        chk("uq_empty_pushpop_count", 32'(uq_count), 32'd1);
        uq_pop = 1'b1;
        tick();
        uq_pop = 1'b0;
        chk("uq_final_count", 32'(uq_count), 32'd0);
        chk("uq_drained", 32'(exp_uq.size()), 32'd0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
